// File: rtl/jtframe_i2s_pkg.sv
// rtl/jtframe_i2s_pkg.sv - shared types and slot-to-stream-bit helper for the I2S sink
// JTFRAME_I2S_LJ_EN selects left-justified bit mapping instead of I2S one-slot delay.
package jtframe_i2s_pkg;

  localparam int DEF_DW     = 16;
  localparam int FRAME_BITS = 2*DEF_DW;

  typedef struct packed {
    logic signed [DEF_DW-1:0] l;
    logic signed [DEF_DW-1:0] r;
  } stereo_t;

  // stream bit 0 is the MSB of L
  function automatic int stream_index(input int slot, input int frame_bits);
`ifdef JTFRAME_I2S_LJ_EN
    return slot;
`else
    return (slot == 0) ? frame_bits - 1 : slot - 1;
`endif
  endfunction

endpackage

// File: rtl/jtframe_i2s_tx_if.sv
// rtl/jtframe_i2s_tx_if.sv - sample-strobed stereo input bundle
interface jtframe_i2s_tx_if #(
  parameter int DW = 16
);
  logic                 sample;
  logic signed [DW-1:0] l_in;
  logic signed [DW-1:0] r_in;

  modport master (output sample, l_in, r_in);
  modport slave  (input  sample, l_in, r_in);
endinterface

// File: rtl/jtframe_i2s_fifo.sv
// rtl/jtframe_i2s_fifo.sv - small synchronous FIFO, pop evaluated before push
module jtframe_i2s_fifo #(
  parameter int W  = 32,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         dropped
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // a pop on the same cycle frees the slot a full FIFO needs
  assign do_push = push && (!full || do_pop);
  assign dropped = push && !do_push;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/jtframe_i2s_tx.sv
// rtl/jtframe_i2s_tx.sv - FIFO-buffered stereo serializer to an I2S DAC
// JTFRAME_I2S_LJ_EN switches the serial format to left-justified.
module jtframe_i2s_tx
  import jtframe_i2s_pkg::*;
#(
  parameter int DW     = 16,
  parameter int CLKDIV = 4,
  parameter int AW     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  jtframe_i2s_tx_if.slave  snd,
  output logic             bclk,
  output logic             lrck,
  output logic             sdata,
  output logic             underrun,
  output logic             overflow
);
  localparam int FW = 2*DW;
  localparam int SW = $clog2(FW);
  localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [SW-1:0] LAST    = SW'(FW-1);
  localparam logic [CW-1:0] DIV_TOP = CW'(CLKDIV-1);

  logic [CW-1:0] div;
  logic [SW-1:0] slot, slot_nx, bit_sel;
  logic [FW-1:0] hold, cur, head;
  logic          fall, load, pop, empty, full, dropped, bit_nx;

  assign fall    = (div == DIV_TOP) && bclk;
  assign slot_nx = (slot == LAST) ? '0 : slot + 1'b1;
  assign load    = fall && (slot_nx == LAST);
  assign pop     = load && !empty;

  jtframe_i2s_fifo #(.W(FW), .AW(AW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (snd.sample),
    .din     ({snd.l_in, snd.r_in}),
    .pop     (pop),
    .dout    (head),
    .empty   (empty),
    .full    (full),
    .dropped (dropped)
  );

  // cur holds the frame being shifted; hold is already the next frame by slot 0
  always_comb begin
    bit_sel = SW'(FW - 1 - stream_index(int'(slot_nx), FW));
`ifdef JTFRAME_I2S_LJ_EN
    bit_nx  = (slot_nx == '0) ? hold[bit_sel] : cur[bit_sel];
`else
    bit_nx  = cur[bit_sel];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div      <= '0;
      bclk     <= 1'b0;
      slot     <= LAST;
      lrck     <= 1'b1;
      sdata    <= 1'b0;
      underrun <= 1'b0;
      overflow <= 1'b0;
      hold     <= '0;
      cur      <= '0;
    end else begin
      underrun <= load && empty;
      if (dropped) overflow <= 1'b1;
      if (div == DIV_TOP) begin
        div  <= '0;
        bclk <= ~bclk;
      end else begin
        div  <= div + 1'b1;
      end
      if (fall) begin
        slot  <= slot_nx;
        lrck  <= (slot_nx >= SW'(DW));
        sdata <= bit_nx;
        if (slot_nx == '0) cur  <= hold;
        if (pop)           hold <= head;
      end
    end
  end

endmodule

// File: tb/tb_jtframe_i2s_tx.sv
// tb/tb_jtframe_i2s_tx.sv - self-checking bench: vector table plus frame scoreboard
module tb_jtframe_i2s_tx;
  import jtframe_i2s_pkg::*;

  localparam int DW = 16, CLKDIV = 2, AW = 2, FW = 32, DEPTH = 4;

  typedef struct {
    stereo_t       pair;
    logic [FW-1:0] exp;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic bclk, lrck, sdata, underrun, overflow;

  jtframe_i2s_tx_if #(.DW(DW)) snd_if ();

  jtframe_i2s_tx #(.DW(DW), .CLKDIV(CLKDIV), .AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .snd      (snd_if),
    .bclk     (bclk),
    .lrck     (lrck),
    .sdata    (sdata),
    .underrun (underrun),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  int            cyc = 0, m_slot = FW-1;
  bit            m_fall = 0, m_und = 0, m_ovf = 0;
  logic [FW-1:0] m_hold = '0;
  logic [FW-1:0] m_fifo[$];
  logic [FW-1:0] exp_q[$];

  logic [FW-1:0] word = '0;
  bit            have = 0;
  logic [FW-1:0] got[$];
  int            und_cnt = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_word(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference model: timing derived from the clk count since reset release
  always @(posedge clk) begin
    if (!rst_n) begin
      cyc = 0; m_slot = FW-1; m_fall = 0; m_und = 0; m_ovf = 0; m_hold = '0;
      m_fifo.delete(); exp_q.delete();
    end else begin
      cyc++;
      m_und  = 0;
      m_fall = (cyc % (2*CLKDIV)) == 0;
      if (m_fall) begin
        m_slot = (m_slot + 1) % FW;
        if (m_slot == FW-1) begin
          if (m_fifo.size() > 0) m_hold = m_fifo.pop_front();
          else m_und = 1;
        end
        if (m_slot == 0) exp_q.push_back(m_hold);
      end
      if (snd_if.sample) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back({snd_if.l_in, snd_if.r_in});
        else m_ovf = 1;
      end
    end
  end

  task automatic finish_word();
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard: word %h with nothing expected", word);
    end else begin
      check_word("frame", word, exp_q.pop_front());
    end
    got.push_back(word);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      have = 0;
    end else if (cyc > 0) begin
      check_bit("bclk", bclk, ((cyc / CLKDIV) % 2) == 1);
      check_bit("underrun", underrun, m_und);
      check_bit("overflow", overflow, m_ovf);
      if (underrun) und_cnt++;
      if (m_fall) begin
        check_bit("lrck", lrck, m_slot >= DW);
`ifdef JTFRAME_I2S_LJ_EN
        if (m_slot == 0) have = 1;
        if (have) begin
          word[FW-1-m_slot] = sdata;
          if (m_slot == FW-1) finish_word();
        end
`else
        if (m_slot == 0) begin
          if (have) begin
            word[0] = sdata;
            finish_word();
          end
        end else begin
          if (m_slot == 1) have = 1;
          if (have) word[FW-m_slot] = sdata;
        end
`endif
      end
    end
  end

  task automatic wait_slot(input int s);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_fall && m_slot == s) && n < 400);
    if (n >= 400) begin
      total++; bad++;
      $display("FAIL wait_slot: slot %0d not reached", s);
    end
  endtask

  task automatic wait_words(input int n);
    int t = 0;
    while (got.size() < n && t < 40*128) begin
      @(negedge clk);
      t++;
    end
    if (got.size() < n) begin
      total++; bad++;
      $display("FAIL wait_words: got %0d words expected %0d", got.size(), n);
    end
  endtask

  task automatic push_pair(input logic [FW-1:0] p);
    snd_if.sample = 1'b1;
    snd_if.l_in   = p[FW-1:DW];
    snd_if.r_in   = p[DW-1:0];
    @(negedge clk);
    snd_if.sample = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_bit({tag, "_bclk"}, bclk, 1'b0);
    check_bit({tag, "_lrck"}, lrck, 1'b1);
    check_bit({tag, "_sdata"}, sdata, 1'b0);
    check_bit({tag, "_underrun"}, underrun, 1'b0);
    check_bit({tag, "_overflow"}, overflow, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          tbl[4];
    logic [FW-1:0] ov[5];
    logic [FW-1:0] fp[5];
    logic [FW-1:0] prev;

    tbl[0] = '{'{16'h8001, 16'h7FFE}, 32'h8001_7FFE};
    tbl[1] = '{'{16'h0000, 16'hFFFF}, 32'h0000_FFFF};
    tbl[2] = '{'{16'hA5A5, 16'h5A5A}, 32'hA5A5_5A5A};
    tbl[3] = '{'{16'h1234, 16'h8765}, 32'h1234_8765};
    ov[0] = 32'h0101_F1F1; ov[1] = 32'h0202_F2F2; ov[2] = 32'h0303_F3F3;
    ov[3] = 32'h0404_F4F4; ov[4] = 32'h0505_F5F5;
    fp[0] = 32'h1111_EEEE; fp[1] = 32'h2222_DDDD; fp[2] = 32'h3333_CCCC;
    fp[3] = 32'h4444_BBBB; fp[4] = 32'hFFFF_0001;

    snd_if.sample = 1'b0; snd_if.l_in = '0; snd_if.r_in = '0;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    prev = '0;
    for (int i = 0; i < 4; i++) begin
      wait_slot(10);
      push_pair(tbl[i].pair);
      got.delete();
      wait_words(2);
      check_word("tbl_prev", got[0], prev);
      check_word("tbl_word", got[1], tbl[i].exp);
      prev = tbl[i].exp;
    end

    wait_slot(5);
    und_cnt = 0;
    got.delete();
    wait_slot(5);
    check_int("underrun_frame1", und_cnt, 1);
    und_cnt = 0;
    wait_slot(5);
    check_int("underrun_frame2", und_cnt, 1);
    wait_words(2);
    check_word("underrun_repeat0", got[0], tbl[3].exp);
    check_word("underrun_repeat1", got[1], tbl[3].exp);

    wait_slot(3);
    for (int k = 0; k < 5; k++) push_pair(ov[k]);
    check_bit("overflow_set", overflow, 1'b1);
    got.delete();
    wait_words(6);
    check_word("ovf_cur", got[0], tbl[3].exp);
    for (int k = 0; k < 4; k++) check_word("ovf_order", got[k+1], ov[k]);
    check_word("ovf_repeat", got[5], ov[3]);
    check_bit("overflow_sticky", overflow, 1'b1);

    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("ovf_clear");
    got.delete();
    rst_n = 1'b1;

    wait_slot(2);
    for (int k = 0; k < 4; k++) push_pair(fp[k]);
    wait_slot(30);
    repeat (2*CLKDIV-1) @(negedge clk);
    push_pair(fp[4]);
    check_bit("fullpop_no_ovf", overflow, 1'b0);
    wait_words(6);
    check_word("fullpop_first", got[0], '0);
    for (int k = 0; k < 5; k++) check_word("fullpop_order", got[k+1], fp[k]);

    wait_slot(10);
    check_bit("mid_sdata", sdata, 1'b1);
    check_bit("mid_lrck", lrck, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    got.delete();
    rst_n = 1'b1;
    wait_words(1);
    check_word("post_reset_zero", got[0], '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
